// File: rtl/ysyx_24110006_axi_pkg.sv
// ysyx_24110006_axi_pkg: AXI response/burst constants, SRAM FSM states, address stepping helper
package ysyx_24110006_axi_pkg;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_RESP = 3'd4
  } state_t;
  // WRAP steps like INCR; only FIXED holds the address
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] b);
    return b == FIXED ? a : a + 32'd4;
  endfunction
endpackage

// File: rtl/ysyx_24110006_axi_sram_if.sv
// if_axi: AXI4 bus (AR/R/AW/W/B), 4-bit id, 32-bit data; master and slave modports
interface if_axi;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [3:0]  arid, rid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  awid, bid, wstrb;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, rid, awready, wready, bvalid, bresp, bid
  );
  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, rid, awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/ysyx_24110006_sram_array.sv
// ysyx_24110006_sram_array: single-port SRAM, synchronous read, per-byte write enables
// Ports: clk, addr (word index), we, be (byte enables), wdata, q (registered read data)
module ysyx_24110006_sram_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [31:0]              wdata,
  output logic [31:0]              q
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    q <= mem[addr];
  end
endmodule

// File: rtl/ysyx_24110006_axi_sram.sv
// ysyx_24110006_axi_sram: AXI4 slave over a single-port SRAM with bursts, byte writes and error responses
// Ports: i_clock (posedge), i_reset (async active-low), i_axi (if_axi.slave).
// Build option: AXI_SRAM_DELAY_EN inserts LFSR-driven 0-7 cycle stalls after every handshake.
module ysyx_24110006_axi_sram import ysyx_24110006_axi_pkg::*; #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          RD_LAT      = 1
) (
  input logic  i_clock,
  input logic  i_reset,
  if_axi.slave i_axi
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIM = 32'(4 * DEPTH_WORDS);
  state_t state;
  logic up, stall, dec, slv, idle, wr_go, ar_go, r_hs, w_hs, b_hs, rvalid, bvalid, last, ok_cur, ok_aw, we;
  logic [7:0] beat, len, wcnt;
  logic [3:0] id;
  logic [1:0] burst;
  logic [31:0] addr, nxt, sel, off_cur, off_aw, off_sel, q;
  logic unused;
  assign unused = ^{off_sel[31:IW+2], off_sel[1:0], i_axi.arsize, i_axi.awsize};
  // up holds the IDLE readies low until the first edge after reset release
  always_comb begin
    idle = state == IDLE && up && !stall;
    wr_go = idle && i_axi.awvalid && i_axi.wvalid;
    ar_go = idle && i_axi.arvalid && !i_axi.awvalid;
    rvalid = state == RD_DATA && !stall;
    bvalid = state == WR_RESP && !stall;
    w_hs = state == WR_DATA && !stall && i_axi.wvalid;
    r_hs = rvalid && i_axi.rready;
    b_hs = bvalid && i_axi.bready;
    last = beat == len;
    nxt = next_addr(addr, burst);
    off_cur = addr - ADDR_BASE;
    off_aw = i_axi.awaddr - ADDR_BASE;
    ok_cur = off_cur < LIM;
    ok_aw = off_aw < LIM;
    // sync-read array: present the next beat's address in the handshake cycle so q is ready with rvalid
    sel = state == IDLE ? (i_axi.awvalid ? i_axi.awaddr : i_axi.araddr) : (r_hs && !last ? nxt : addr);
    off_sel = sel - ADDR_BASE;
    we = (wr_go && ok_aw) || (w_hs && ok_cur);
  end
  assign i_axi.awready = idle;
  assign i_axi.wready = idle || (state == WR_DATA && !stall);
  assign i_axi.arready = idle && !i_axi.awvalid;
  assign i_axi.rvalid = rvalid;
  assign i_axi.rdata = rvalid && ok_cur ? q : 32'd0;
  assign i_axi.rresp = rvalid && !ok_cur ? DECERR : OKAY;
  assign i_axi.rlast = rvalid && last;
  assign i_axi.rid = id;
  assign i_axi.bvalid = bvalid;
  assign i_axi.bresp = !bvalid ? OKAY : dec ? DECERR : slv ? SLVERR : OKAY;
  assign i_axi.bid = id;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= IDLE;
      up <= 1'b0;
      beat <= '0;
      len <= '0;
      wcnt <= '0;
      id <= '0;
      burst <= '0;
      addr <= '0;
      dec <= 1'b0;
      slv <= 1'b0;
    end else begin
      up <= 1'b1;
      if (ar_go) begin
        state <= RD_LAT == 1 ? RD_DATA : RD_WAIT;
        addr <= i_axi.araddr;
        len <= i_axi.arlen;
        id <= i_axi.arid;
        burst <= i_axi.arburst;
        beat <= '0;
        wcnt <= '0;
      end
      // first W beat rides with AW, so the burst continues at beat 1
      if (wr_go) begin
        state <= i_axi.awlen == 8'd0 ? WR_RESP : WR_DATA;
        addr <= next_addr(i_axi.awaddr, i_axi.awburst);
        len <= i_axi.awlen;
        id <= i_axi.awid;
        burst <= i_axi.awburst;
        beat <= 8'd1;
        dec <= !ok_aw;
        slv <= i_axi.wlast != (i_axi.awlen == 8'd0);
      end
      if (state == RD_WAIT) begin
        wcnt <= wcnt + 8'd1;
        if (wcnt == 8'(RD_LAT - 2)) state <= RD_DATA;
      end
      if (r_hs) begin
        beat <= beat + 8'd1;
        addr <= nxt;
        if (last) state <= IDLE;
      end
      if (w_hs) begin
        beat <= beat + 8'd1;
        addr <= nxt;
        dec <= dec | !ok_cur;
        slv <= slv | (i_axi.wlast != last);
        if (last) state <= WR_RESP;
      end
      if (b_hs) state <= IDLE;
    end
  end
`ifdef AXI_SRAM_DELAY_EN
  logic [7:0] lfsr;
  logic [2:0] cnt;
  assign stall = cnt != 3'd0;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      lfsr <= 8'hA5;
      cnt <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      cnt <= (wr_go || ar_go || r_hs || w_hs || b_hs) ? lfsr[2:0] : cnt - 3'(stall);
    end
  end
`else
  assign stall = 1'b0;
`endif
  ysyx_24110006_sram_array #(.DEPTH(DEPTH_WORDS)) u_array (
    .clk(i_clock),
    .addr(off_sel[IW+1:2]),
    .we(we),
    .be(i_axi.wstrb),
    .wdata(i_axi.wdata),
    .q(q)
  );
endmodule
